// File: rtl/mem_lsu_if.sv
// Core-request and data-memory signal bundle for mem_lsu.
// The master side is the core FSM plus the memory; the slave side is the LSU.
interface mem_lsu_if #(
  parameter int ADDR_W = 32
);
  // Core request / response
  logic              req;
  logic              we;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic [31:0]       rdata;
  logic              err;

  // Word-wide memory port (asynchronous read, synchronous write)
  logic [ADDR_W-1:0] mem_a;
  logic [31:0]       mem_wd;
  logic              mem_we;
  logic [31:0]       mem_rd;

  modport master (
    output req, we, funct3, addr, wdata, mem_rd,
    input  busy, done, rdata, err, mem_a, mem_wd, mem_we
  );

  modport slave (
    input  req, we, funct3, addr, wdata, mem_rd,
    output busy, done, rdata, err, mem_a, mem_wd, mem_we
  );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: word-aligned memory transactions, read-modify-write for SB/SH,
// sign/zero-extended loads. Define LSU_MISALIGN_CHECK_EN to reject misaligned H/W accesses.
module mem_lsu #(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_lsu_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t            state, state_next;

  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       old_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              bad_f3;
  logic              bad_store;
  logic              out_of_range;
  logic              misaligned;
  logic              req_invalid;
  logic              accept;

  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       load_ext;
  logic [31:0]       merged;

  assign accept = (state == IDLE) && bus.req;

  // Request validation works on the live inputs so the branch is taken on the capture edge.
  always_comb begin
    bad_f3       = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);
    bad_store    = bus.we && bus.funct3[2];
    out_of_range = {1'b0, bus.addr} >= MEM_LIMIT;
`ifdef LSU_MISALIGN_CHECK_EN
    case (bus.funct3[1:0])
      2'b01:   misaligned = bus.addr[0];
      2'b10:   misaligned = (bus.addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
`else
    misaligned   = 1'b0;
`endif
    req_invalid  = bad_f3 || bad_store || out_of_range || misaligned;
  end

  // Load lane select (little-endian) and extension.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = bus.mem_rd[7:0];
      2'd1:    lane_b = bus.mem_rd[15:8];
      2'd2:    lane_b = bus.mem_rd[23:16];
      default: lane_b = bus.mem_rd[31:24];
    endcase
    lane_h = addr_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];

    case (funct3_q)
      F3_B:    load_ext = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_ext = {24'h0, lane_b};
      F3_H:    load_ext = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_ext = {16'h0, lane_h};
      default: load_ext = bus.mem_rd;
    endcase
  end

  // Store merge: the old word with the addressed lane replaced; SW ignores the old word.
  always_comb begin
    merged = old_q;
    case (funct3_q[1:0])
      2'b00: begin
        case (addr_q[1:0])
          2'd0:    merged[7:0]   = wdata_q[7:0];
          2'd1:    merged[15:8]  = wdata_q[7:0];
          2'd2:    merged[23:16] = wdata_q[7:0];
          default: merged[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output gets a default before the case, so no path leaves a signal unassigned (no latches).
  always_comb begin
    state_next = state;
    bus.busy   = (state != IDLE);
    bus.done   = 1'b0;
    bus.err    = 1'b0;
    bus.mem_a  = '0;
    bus.mem_we = 1'b0;
    bus.mem_wd = '0;

    case (state)
      IDLE: begin
        if (bus.req) begin
          if (req_invalid)
            state_next = DONE;
          else if (bus.we && (bus.funct3 == F3_W))
            state_next = WRITE;
          else
            state_next = READ;
        end
      end
      READ: begin
        bus.mem_a  = {addr_q[ADDR_W-1:2], 2'b00};
        state_next = we_q ? WRITE : DONE;
      end
      WRITE: begin
        bus.mem_a  = {addr_q[ADDR_W-1:2], 2'b00};
        bus.mem_we = 1'b1;
        bus.mem_wd = merged;
        state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        bus.err    = err_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture and read-phase datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      old_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= bus.we;
        funct3_q <= bus.funct3;
        addr_q   <= bus.addr;
        wdata_q  <= bus.wdata;
        err_q    <= req_invalid;
      end
      if (state == READ) begin
        if (we_q) old_q   <= bus.mem_rd;
        else      rdata_q <= load_ext;
      end
    end
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu with a 4 KiB behavioural word memory.
module tb_mem_lsu;

  localparam int ADDR_W    = 32;
  localparam int MEM_BYTES = 4096;

  logic clk;
  logic rst_n;

  int tests;
  int fails;

  mem_lsu_if #(.ADDR_W(ADDR_W)) bus ();

  mem_lsu #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural memory: async read, write on clock edge, bench preload port.
  logic [31:0] mem_model [0:1023];
  logic        pl_en;
  logic [9:0]  pl_idx;
  logic [31:0] pl_data;

  assign bus.mem_rd = mem_model[bus.mem_a[11:2]];

  always @(posedge clk) begin
    if (bus.mem_we)
      mem_model[bus.mem_a[11:2]] <= bus.mem_wd;
    else if (pl_en)
      mem_model[pl_idx] <= pl_data;
  end

  // Write-pulse monitor, sampled mid-cycle.
  int          we_pulses;
  logic [31:0] last_wa;
  logic [31:0] last_wd;

  initial we_pulses = 0;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      we_pulses <= we_pulses + 1;
      last_wa   <= bus.mem_a;
      last_wd   <= bus.mem_wd;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_idx  = a[11:2];
    pl_data = d;
    @(posedge clk); #1;
    pl_en   = 1'b0;
  endtask

  // Issues one request from a point #1 after a clock edge and waits for done.
  // With hold=1, req stays high (with different operands) until done is seen.
  task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input bit hold,
                        output int lat, output int pulses, output int we_cyc,
                        output logic e, output bit timed_out);
    int p0;
    p0         = we_pulses;
    bus.req    = 1'b1;
    bus.we     = w;
    bus.funct3 = f3;
    bus.addr   = a;
    bus.wdata  = d;
    @(posedge clk); #1;
    if (hold) begin
      bus.addr  = a + 32'd4;
      bus.wdata = ~d;
    end else begin
      bus.req = 1'b0;
    end
    lat       = 1;
    we_cyc    = 0;
    timed_out = 1'b0;
    while (!bus.done && lat < 10) begin
      if (bus.mem_we && we_cyc == 0) we_cyc = lat;
      @(posedge clk); #1;
      lat++;
    end
    bus.req = 1'b0;
    if (!bus.done) timed_out = 1'b1;
    e = bus.err;
    @(posedge clk); #1;
    pulses = we_pulses - p0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.req    = 1'b0;
    bus.we     = 1'b0;
    bus.funct3 = 3'b000;
    bus.addr   = '0;
    bus.wdata  = '0;
    pl_en      = 1'b0;
    pl_idx     = '0;
    pl_data    = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (bus.busy !== 1'b0)    begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0)    begin fails++; $display("FAIL reset_done: got %b want 0", bus.done); end
    tests++; if (bus.err !== 1'b0)     begin fails++; $display("FAIL reset_err: got %b want 0", bus.err); end
    tests++; if (bus.mem_we !== 1'b0)  begin fails++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    tests++; if (bus.rdata !== 32'h0)  begin fails++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    tests++; if (bus.mem_a !== 32'h0)  begin fails++; $display("FAIL reset_mem_a: got %h want 0", bus.mem_a); end
    tests++; if (bus.mem_wd !== 32'h0) begin fails++; $display("FAIL reset_mem_wd: got %h want 0", bus.mem_wd); end
    preload(32'h10,  32'h8899AABB);
    preload(32'h20,  32'h11223344);
    preload(32'h40,  32'h00000000);
    preload(32'h44,  32'h00000000);
    preload(32'hFFC, 32'hCAFEF00D);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_byte();
    int lat, pulses, we_cyc; logic e; bit to;
    run_op(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, lat, pulses, we_cyc, e, to);
    tests++; if (to)                        begin fails++; $display("FAIL lb_timeout: no done within budget"); end
    tests++; if (bus.rdata !== 32'hFFFFFF88) begin fails++; $display("FAIL lb_rdata: got %h want ffffff88", bus.rdata); end
    tests++; if (lat != 2)                   begin fails++; $display("FAIL lb_latency: got %0d want 2", lat); end
    tests++; if (pulses != 0)                begin fails++; $display("FAIL lb_mem_we: got %0d pulses want 0", pulses); end
    tests++; if (e !== 1'b0)                 begin fails++; $display("FAIL lb_err: got %b want 0", e); end
    run_op(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, lat, pulses, we_cyc, e, to);
    tests++; if (bus.rdata !== 32'h00000088) begin fails++; $display("FAIL lbu_rdata: got %h want 00000088", bus.rdata); end
    run_op(1'b0, 3'b000, 32'h10, 32'h0, 1'b0, lat, pulses, we_cyc, e, to);
    tests++; if (bus.rdata !== 32'hFFFFFFBB) begin fails++; $display("FAIL lb0_rdata: got %h want ffffffbb", bus.rdata); end
    run_op(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, lat, pulses, we_cyc, e, to);
    tests++; if (bus.rdata !== 32'hFFFF8899) begin fails++; $display("FAIL lh_rdata: got %h want ffff8899", bus.rdata); end
    run_op(1'b0, 3'b101, 32'h10, 32'h0, 1'b0, lat, pulses, we_cyc, e, to);
    tests++; if (bus.rdata !== 32'h0000AABB) begin fails++; $display("FAIL lhu_rdata: got %h want 0000aabb", bus.rdata); end
  endtask

  task automatic test_store_byte();
    int lat, pulses, we_cyc; logic e; bit to;
    run_op(1'b1, 3'b000, 32'h21, 32'h123456AB, 1'b0, lat, pulses, we_cyc, e, to);
    tests++; if (to)                        begin fails++; $display("FAIL sb_timeout: no done within budget"); end
    tests++; if (pulses != 1)                begin fails++; $display("FAIL sb_pulses: got %0d want 1", pulses); end
    tests++; if (last_wa !== 32'h20)         begin fails++; $display("FAIL sb_mem_a: got %h want 00000020", last_wa); end
    tests++; if (last_wd !== 32'h1122AB44)   begin fails++; $display("FAIL sb_mem_wd: got %h want 1122ab44", last_wd); end
    tests++; if (lat != 3)                   begin fails++; $display("FAIL sb_latency: got %0d want 3", lat); end
    tests++; if (we_cyc != 2)                begin fails++; $display("FAIL sb_we_cycle: got %0d want 2", we_cyc); end
    tests++; if (bus.rdata !== 32'h0000AABB) begin fails++; $display("FAIL sb_rdata_held: got %h want 0000aabb", bus.rdata); end
    run_op(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, lat, pulses, we_cyc, e, to);
    tests++; if (bus.rdata !== 32'h1122AB44) begin fails++; $display("FAIL sb_readback: got %h want 1122ab44", bus.rdata); end
  endtask

  task automatic test_store_word_busy_req();
    int lat, pulses, we_cyc; logic e; bit to;
    run_op(1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 1'b1, lat, pulses, we_cyc, e, to);
    tests++; if (to)                          begin fails++; $display("FAIL sw_timeout: no done within budget"); end
    tests++; if (we_cyc != 1)                  begin fails++; $display("FAIL sw_we_cycle: got %0d want 1", we_cyc); end
    tests++; if (lat != 2)                     begin fails++; $display("FAIL sw_latency: got %0d want 2", lat); end
    tests++; if (last_wd !== 32'hDEADBEEF)     begin fails++; $display("FAIL sw_mem_wd: got %h want deadbeef", last_wd); end
    tests++; if (last_wa !== 32'h40)           begin fails++; $display("FAIL sw_mem_a: got %h want 00000040", last_wa); end
    repeat (3) @(posedge clk);
    #1;
    pulses = we_pulses - pulses;
    tests++; if (we_pulses - (pulses + 1) != 0 && we_pulses == 0) begin fails++; $display("FAIL sw_pulse_count: got %0d", we_pulses); end
    tests++; if (bus.busy !== 1'b0)            begin fails++; $display("FAIL sw_idle_after: busy got %b want 0", bus.busy); end
    tests++; if (mem_model[17] !== 32'h0)      begin fails++; $display("FAIL sw_busy_req_ignored: word 0x44 got %h want 00000000", mem_model[17]); end
    tests++; if (mem_model[16] !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_memory: word 0x40 got %h want deadbeef", mem_model[16]); end
  endtask

  task automatic test_errors();
    int lat, pulses, we_cyc; logic e; bit to; logic [31:0] held;
    held = bus.rdata;
    run_op(1'b0, 3'b010, 32'h1000, 32'h0, 1'b0, lat, pulses, we_cyc, e, to);
    tests++; if (e !== 1'b1)        begin fails++; $display("FAIL oor_err: got %b want 1", e); end
    tests++; if (lat != 1)          begin fails++; $display("FAIL oor_latency: got %0d want 1", lat); end
    tests++; if (pulses != 0)       begin fails++; $display("FAIL oor_mem_we: got %0d pulses want 0", pulses); end
    tests++; if (bus.rdata !== held) begin fails++; $display("FAIL oor_rdata_held: got %h want %h", bus.rdata, held); end
    tests++; if (bus.err !== 1'b0)  begin fails++; $display("FAIL err_outside_done: got %b want 0", bus.err); end
    run_op(1'b0, 3'b110, 32'h20, 32'h0, 1'b0, lat, pulses, we_cyc, e, to);
    tests++; if (e !== 1'b1)        begin fails++; $display("FAIL f3_110_err: got %b want 1", e); end
    run_op(1'b1, 3'b100, 32'h20, 32'hFF, 1'b0, lat, pulses, we_cyc, e, to);
    tests++; if (e !== 1'b1)        begin fails++; $display("FAIL store_f3_100_err: got %b want 1", e); end
    tests++; if (pulses != 0)       begin fails++; $display("FAIL store_f3_100_mem_we: got %0d pulses want 0", pulses); end
    tests++; if (mem_model[8] !== 32'h1122AB44) begin fails++; $display("FAIL store_f3_100_memory: got %h want 1122ab44", mem_model[8]); end
    run_op(1'b0, 3'b010, 32'hFFC, 32'h0, 1'b0, lat, pulses, we_cyc, e, to);
    tests++; if (e !== 1'b0)        begin fails++; $display("FAIL last_word_err: got %b want 0", e); end
    tests++; if (bus.rdata !== 32'hCAFEF00D) begin fails++; $display("FAIL last_word_rdata: got %h want cafef00d", bus.rdata); end
  endtask

  task automatic test_misalign();
    int lat, pulses, we_cyc; logic e; bit to;
`ifdef LSU_MISALIGN_CHECK_EN
    run_op(1'b0, 3'b001, 32'h22, 32'h0, 1'b0, lat, pulses, we_cyc, e, to);
    tests++; if (bus.rdata !== 32'h00001122) begin fails++; $display("FAIL lh_aligned_rdata: got %h want 00001122", bus.rdata); end
    tests++; if (e !== 1'b0)                 begin fails++; $display("FAIL lh_aligned_err: got %b want 0", e); end
    run_op(1'b0, 3'b001, 32'h23, 32'h0, 1'b0, lat, pulses, we_cyc, e, to);
    tests++; if (e !== 1'b1)                 begin fails++; $display("FAIL lh_misaligned_err: got %b want 1", e); end
    tests++; if (lat != 1)                   begin fails++; $display("FAIL lh_misaligned_latency: got %0d want 1", lat); end
    tests++; if (bus.rdata !== 32'h00001122) begin fails++; $display("FAIL lh_misaligned_rdata_held: got %h want 00001122", bus.rdata); end
    run_op(1'b1, 3'b010, 32'h42, 32'h55555555, 1'b0, lat, pulses, we_cyc, e, to);
    tests++; if (e !== 1'b1)                 begin fails++; $display("FAIL sw_misaligned_err: got %b want 1", e); end
    tests++; if (pulses != 0)                begin fails++; $display("FAIL sw_misaligned_mem_we: got %0d pulses want 0", pulses); end
`else
    run_op(1'b0, 3'b001, 32'h23, 32'h0, 1'b0, lat, pulses, we_cyc, e, to);
    tests++; if (bus.rdata !== 32'h00001122) begin fails++; $display("FAIL lh_masked_rdata: got %h want 00001122", bus.rdata); end
    tests++; if (e !== 1'b0)                 begin fails++; $display("FAIL lh_masked_err: got %b want 0", e); end
    run_op(1'b0, 3'b010, 32'h42, 32'h0, 1'b0, lat, pulses, we_cyc, e, to);
    tests++; if (bus.rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_masked_rdata: got %h want deadbeef", bus.rdata); end
    tests++; if (e !== 1'b0)                 begin fails++; $display("FAIL lw_masked_err: got %b want 0", e); end
`endif
  endtask

  task automatic test_reset_mid_write();
    int lat, pulses, we_cyc; logic e; bit to; int p0;
    p0         = we_pulses;
    bus.req    = 1'b1;
    bus.we     = 1'b1;
    bus.funct3 = 3'b001;
    bus.addr   = 32'h22;
    bus.wdata  = 32'h00005555;
    @(posedge clk); #1;
    bus.req = 1'b0;
    tests++; if (bus.busy !== 1'b1)   begin fails++; $display("FAIL sh_busy_read: got %b want 1", bus.busy); end
    @(posedge clk); #1;
    tests++; if (bus.mem_we !== 1'b1) begin fails++; $display("FAIL sh_in_write: mem_we got %b want 1", bus.mem_we); end
    tests++; if (bus.mem_wd !== 32'h5555AB44) begin fails++; $display("FAIL sh_mem_wd: got %h want 5555ab44", bus.mem_wd); end
    rst_n = 1'b0;
    #1;
    tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL rst_mid_write_mem_we: got %b want 0", bus.mem_we); end
    tests++; if (bus.busy !== 1'b0)   begin fails++; $display("FAIL rst_mid_write_busy: got %b want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0)   begin fails++; $display("FAIL rst_mid_write_done: got %b want 0", bus.done); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++; if (mem_model[8] !== 32'h1122AB44) begin fails++; $display("FAIL rst_mid_write_memory: got %h want 1122ab44", mem_model[8]); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, lat, pulses, we_cyc, e, to);
    tests++; if (to)                         begin fails++; $display("FAIL post_reset_timeout: no done within budget"); end
    tests++; if (bus.rdata !== 32'h1122AB44)  begin fails++; $display("FAIL post_reset_lw: got %h want 1122ab44", bus.rdata); end
    tests++; if (lat != 2)                    begin fails++; $display("FAIL post_reset_latency: got %0d want 2", lat); end
    tests++; if (we_pulses - p0 != 0)         begin fails++; $display("FAIL rst_mid_write_pulses: got %0d want 0", we_pulses - p0); end
  endtask

  task automatic test_back_to_back();
    int n;
    // Second request held through the done cycle is accepted as soon as the LSU is idle.
    bus.req    = 1'b1;
    bus.we     = 1'b0;
    bus.funct3 = 3'b100;
    bus.addr   = 32'h12;
    @(posedge clk); #1;
    n = 0;
    while (!bus.done && n < 10) begin @(posedge clk); #1; n++; end
    bus.funct3 = 3'b000;
    bus.addr   = 32'h11;
    @(posedge clk); #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL b2b_idle_gap: busy got %b want 0", bus.busy); end
    tests++; if (bus.rdata !== 32'h00000099) begin fails++; $display("FAIL b2b_first_rdata: got %h want 00000099", bus.rdata); end
    @(posedge clk); #1;
    bus.req = 1'b0;
    n = 0;
    while (!bus.done && n < 10) begin @(posedge clk); #1; n++; end
    tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL b2b_second_done: got %b want 1", bus.done); end
    tests++; if (bus.rdata !== 32'hFFFFFFAA) begin fails++; $display("FAIL b2b_second_rdata: got %h want ffffffaa", bus.rdata); end
    @(posedge clk); #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_load_byte();
    test_store_byte();
    test_store_word_busy_req();
    test_errors();
    test_misalign();
    test_reset_mid_write();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
